vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the board clock.
- Produces the pixel strobe, sync pulses, active-area flag and current pixel coordinates (o_active, o_x, o_y) consumed by every sprite/ball/bar renderer in the video path.
- Drives the sync pins of the VGA connector directly.

Parameters:
- CLK_DIV, 2: board clocks per pixel (50 MHz -> 25 MHz pixel rate); legal values >= 1.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BP, 33: vertical back porch, in lines.

Ports:
- clk_in  input  1  board clock; the only clock.
- i_rst  input  1  asynchronous, active-low reset.
- o_pix_stb  output  1  one-clk pulse, every CLK_DIV clocks, marking each pixel advance.
- o_hs  output  1  hsync, active low.
- o_vs  output  1  vsync, active low.
- o_active  output  1  high while the current pixel is in the visible area.
- o_x  output  10  current visible column 0..639; 0 outside the visible area.
- o_y  output  9  current visible row 0..479; 0 outside the visible area.
- o_line_end  output  1  one-clk pulse when h wraps from the last pixel of a line to 0.
- o_frame_end  output  1  one-clk pulse when the raster enters the first blanking line (v becomes V_ACTIVE, h = 0).

Behaviour:
- Internal counters:
  - div_cnt runs 0..CLK_DIV-1 and wraps.
  - stb is asserted when div_cnt == CLK_DIV-1; with CLK_DIV = 1, stb is constantly high.
  - h_cnt is 10 bits, 0..H_TOTAL-1, with H_TOTAL = 800.
  - v_cnt is 10 bits, 0..V_TOTAL-1, with V_TOTAL = 525.
- Counter advance on stb:
  - h_cnt increments.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 at V_TOTAL-1 when h_cnt also wraps.
- Output timing:
  - All outputs are registered.
  - On the stb edge, outputs are decoded from the next counter values, so outputs change on the same clk edge as the counters and stay aligned with them.
  - o_pix_stb is the registered stb. It is high in the clk cycle in which the new pixel position first appears on the outputs.
- Output decoding:
  - o_hs = 0 while H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751); 1 otherwise.
  - o_vs = 0 while V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491); 1 otherwise.
  - o_active = (h < H_ACTIVE) && (v < V_ACTIVE).
  - o_x = h[9:0] and o_y = v[8:0] when o_active; both forced to 0 otherwise.
  - The pixel (639,479) is therefore presented for exactly CLK_DIV clocks per frame.
- Strobe outputs:
  - o_line_end and o_frame_end are single-clk pulses, coincident with the o_pix_stb of the new position.
  - Both are high together when the raster moves to (h = 0, v = 480).
- Reset (i_rst low, asynchronous):
  - div_cnt, h_cnt and v_cnt go to 0.
  - o_hs = 1, o_vs = 1, o_active = 1, o_x = 0, o_y = 0.
  - o_pix_stb = 0, o_line_end = 0, o_frame_end = 0.
  - Reset asserted mid-frame aborts the frame immediately.
  - After release, the first stb occurs CLK_DIV clocks later and moves the raster to (1,0).
- No state machine beyond the counters. Sync and active decoding are pure range comparisons, with no off-by-one slack.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- When defined:
  - Adds output port o_pattern [2:0], registered and aligned with o_x.
  - Value = column-bar index 0..7: eight 80-pixel-wide bars, index incrementing at x = 80, 160, ..., 560.
  - Implemented with a bar counter reset at each line start, not a divider.
  - Forced to 0 when o_active = 0.
  - Reset value 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, defaults: first o_pix_stb 2 clks after release; o_x = 1, o_y = 0, o_active = 1; o_hs = 1, o_vs = 1.
- Run one line: o_line_end pulses every 1600 clks. o_hs is low for exactly 192 clks, starting 1312 clks after h = 0. o_active is high for 1280 clks per visible line.
- Run full frame: o_frame_end pulses once per 840000 clks, at (h = 0, v = 480). o_vs is low for exactly 3200 clks, during v = 490..491. (639,479) with o_active = 1 is seen for exactly 2 clks per frame.
- Blanking: for every h >= 640 or v >= 480, o_active = 0 and o_x = o_y = 0.
- Mid-frame reset at v = 200, h = 300: outputs jump to reset values asynchronously (before the next clk edge); the next frame restarts from (0,0) with correct periods.
- CLK_DIV = 1 with VGA_TEST_PATTERN_EN: o_pix_stb is high every clk after reset release; line period is 800 clks; o_pattern = 0 at x = 0..79, 1 at x = 80, 7 at x = 639, 0 at x = 640.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel strobe, syncs, active flag, coordinates, line/frame strobes.
// Latency: none, wires only; the master registers every signal.
// Backpressure: none; consumers sample on the pixel strobe and cannot stall the raster.
//
// Signals:
//   o_pix_stb   one-clk pulse per pixel advance
//   o_hs, o_vs  horizontal / vertical sync, active low
//   o_active    current pixel lies in the visible area
//   o_x, o_y    visible column / row, 0 outside the visible area
//   o_line_end  pulse when the raster wraps to the start of a line
//   o_frame_end pulse when the raster enters the first blanking line
//   o_pattern   colour-bar index 0..7 (only with VGA_TEST_PATTERN_EN)

interface vga_timing_gen_if;
    logic       o_pix_stb;
    logic       o_hs;
    logic       o_vs;
    logic       o_active;
    logic [9:0] o_x;
    logic [8:0] o_y;
    logic       o_line_end;
    logic       o_frame_end;
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] o_pattern;
`endif

    modport master (
        output o_pix_stb,
        output o_hs,
        output o_vs,
        output o_active,
        output o_x,
        output o_y,
        output o_line_end,
`ifdef VGA_TEST_PATTERN_EN
        output o_pattern,
`endif
        output o_frame_end
    );

    modport slave (
        input o_pix_stb,
        input o_hs,
        input o_vs,
        input o_active,
        input o_x,
        input o_y,
        input o_line_end,
`ifdef VGA_TEST_PATTERN_EN
        input o_pattern,
`endif
        input o_frame_end
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480@60 by default) with pixel-rate divider.
// Latency: outputs are registered and change on the same clk edge as the counters.
// Backpressure: none; the raster free-runs and consumers follow o_pix_stb.
//
// Ports:
//   clk_in   board clock, the only clock
//   i_rst    asynchronous active-low reset; aborts the current frame
//   vid      vga_timing_gen_if.master carrying all timing outputs
//
// Optional feature: define VGA_TEST_PATTERN_EN to add vid.o_pattern, an
// eight-bar column index (80-pixel bars) aligned with vid.o_x.

module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic              clk_in,
    input  logic              i_rst,
    vga_timing_gen_if.master  vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counter bounds, pre-sized to the 10-bit counters.
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    // A 1-bit divider is kept for CLK_DIV = 1; it then sits at 0 and the
    // strobe compare is always true.
    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // ------------------------------------------------------------------
    // Pixel-rate divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic             stb;

    assign stb = (div_cnt == DIV_LAST);

    always_ff @(posedge clk_in or negedge i_rst) begin
        if (!i_rst) begin
            div_cnt <= '0;
        end else if (stb) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Raster position: current and next values
    // ------------------------------------------------------------------
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       h_wrap;

    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        h_nxt  = h_wrap ? 10'd0 : h_cnt + 10'd1;
        v_nxt  = v_cnt;
        if (h_wrap) begin
            v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end
    end

    always_ff @(posedge clk_in or negedge i_rst) begin
        if (!i_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (stb) begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the next position, so the registered outputs
    // describe the same pixel the counters hold after the edge.
    // ------------------------------------------------------------------
    logic       hs_nxt;
    logic       vs_nxt;
    logic       act_nxt;
    logic [9:0] x_nxt;
    logic [8:0] y_nxt;
    logic       frame_nxt;

    always_comb begin
        hs_nxt    = !((h_nxt >= HS_BEGIN) && (h_nxt < HS_END));
        vs_nxt    = !((v_nxt >= VS_BEGIN) && (v_nxt < VS_END));
        act_nxt   = (h_nxt < H_VIS) && (v_nxt < V_VIS);
        x_nxt     = act_nxt ? h_nxt : 10'd0;
        y_nxt     = act_nxt ? v_nxt[8:0] : 9'd0;
        frame_nxt = h_wrap && (v_nxt == V_VIS);
    end

    logic       pix_stb_q;
    logic       hs_q;
    logic       vs_q;
    logic       act_q;
    logic [9:0] x_q;
    logic [8:0] y_q;
    logic       line_end_q;
    logic       frame_end_q;

    always_ff @(posedge clk_in or negedge i_rst) begin
        if (!i_rst) begin
            pix_stb_q   <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            act_q       <= 1'b1;   // (0,0) is visible
            x_q         <= '0;
            y_q         <= '0;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
        end else if (stb) begin
            pix_stb_q   <= 1'b1;
            hs_q        <= hs_nxt;
            vs_q        <= vs_nxt;
            act_q       <= act_nxt;
            x_q         <= x_nxt;
            y_q         <= y_nxt;
            line_end_q  <= h_wrap;
            frame_end_q <= frame_nxt;
        end else begin
            // Level outputs hold; the strobes last a single clk.
            pix_stb_q   <= 1'b0;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
        end
    end

    assign vid.o_pix_stb   = pix_stb_q;
    assign vid.o_hs        = hs_q;
    assign vid.o_vs        = vs_q;
    assign vid.o_active    = act_q;
    assign vid.o_x         = x_q;
    assign vid.o_y         = y_q;
    assign vid.o_line_end  = line_end_q;
    assign vid.o_frame_end = frame_end_q;

`ifdef VGA_TEST_PATTERN_EN
    // ------------------------------------------------------------------
    // Column bars: a pixel-in-bar counter that rolls the bar index every
    // 80 pixels, cleared at each line start. Past the visible area the
    // index may keep rolling; the output is masked there anyway.
    // ------------------------------------------------------------------
    localparam logic [6:0] BAR_LAST = 7'd79;

    logic [6:0] bar_px;
    logic [2:0] bar_idx;
    logic [6:0] bar_px_nxt;
    logic [2:0] bar_idx_nxt;
    logic [2:0] pat_q;

    always_comb begin
        bar_px_nxt  = bar_px + 7'd1;
        bar_idx_nxt = bar_idx;
        if (h_wrap) begin
            bar_px_nxt  = '0;
            bar_idx_nxt = '0;
        end else if (bar_px == BAR_LAST) begin
            bar_px_nxt  = '0;
            bar_idx_nxt = bar_idx + 3'd1;
        end
    end

    always_ff @(posedge clk_in or negedge i_rst) begin
        if (!i_rst) begin
            bar_px  <= '0;
            bar_idx <= '0;
            pat_q   <= '0;
        end else if (stb) begin
            bar_px  <= bar_px_nxt;
            bar_idx <= bar_idx_nxt;
            pat_q   <= act_nxt ? bar_idx_nxt : 3'd0;
        end
    end

    assign vid.o_pattern = pat_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances share one clock --
//   u_a full 640x480 timing, CLK_DIV = 2 (line-level timing)
//   u_b shrunken 16x8 raster (25x15 total), CLK_DIV = 2 (frame-level timing, mid-frame reset)
//   u_c full timing, CLK_DIV = 1 (strobe every clk, test pattern when enabled)
// Every cycle each instance is compared with a position-from-elapsed-clocks model.

module tb_vga_timing_gen;

    logic clk    = 1'b0;
    logic rst_a  = 1'b1;
    logic rst_b  = 1'b1;
    logic rst_c  = 1'b1;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen_if if_a ();
    vga_timing_gen_if if_b ();
    vga_timing_gen_if if_c ();

    vga_timing_gen #(.CLK_DIV(2)) u_a (.clk_in(clk), .i_rst(rst_a), .vid(if_a));

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_b (.clk_in(clk), .i_rst(rst_b), .vid(if_b));

    vga_timing_gen #(.CLK_DIV(1)) u_c (.clk_in(clk), .i_rst(rst_c), .vid(if_c));

    typedef struct packed {
        logic       stb;
        logic       hs;
        logic       vs;
        logic       act;
        logic [9:0] x;
        logic [8:0] y;
        logic       le;
        logic       fe;
        logic [2:0] pat;
    } obs_t;

    obs_t obs_a, obs_b, obs_c;

`ifdef VGA_TEST_PATTERN_EN
    assign obs_a = {if_a.o_pix_stb, if_a.o_hs, if_a.o_vs, if_a.o_active, if_a.o_x, if_a.o_y,
                    if_a.o_line_end, if_a.o_frame_end, if_a.o_pattern};
    assign obs_b = {if_b.o_pix_stb, if_b.o_hs, if_b.o_vs, if_b.o_active, if_b.o_x, if_b.o_y,
                    if_b.o_line_end, if_b.o_frame_end, if_b.o_pattern};
    assign obs_c = {if_c.o_pix_stb, if_c.o_hs, if_c.o_vs, if_c.o_active, if_c.o_x, if_c.o_y,
                    if_c.o_line_end, if_c.o_frame_end, if_c.o_pattern};
`else
    assign obs_a = {if_a.o_pix_stb, if_a.o_hs, if_a.o_vs, if_a.o_active, if_a.o_x, if_a.o_y,
                    if_a.o_line_end, if_a.o_frame_end, 3'b000};
    assign obs_b = {if_b.o_pix_stb, if_b.o_hs, if_b.o_vs, if_b.o_active, if_b.o_x, if_b.o_y,
                    if_b.o_line_end, if_b.o_frame_end, 3'b000};
    assign obs_c = {if_c.o_pix_stb, if_c.o_hs, if_c.o_vs, if_c.o_active, if_c.o_x, if_c.o_y,
                    if_c.o_line_end, if_c.o_frame_end, 3'b000};
`endif

    // Clocks elapsed since reset release; the model derives everything from it.
    int k_a = 0, k_b = 0, k_c = 0;

    always @(posedge clk or negedge rst_a) if (!rst_a) k_a <= 0; else k_a <= k_a + 1;
    always @(posedge clk or negedge rst_b) if (!rst_b) k_b <= 0; else k_b <= k_b + 1;
    always @(posedge clk or negedge rst_c) if (!rst_c) k_c <= 0; else k_c <= k_c + 1;

    // After k clocks, k/cdiv pixels have been stepped through; position is
    // that count modulo the frame size, and every output is a range test on it.
    function automatic obs_t model(input int cdiv, input int ha, input int hfp, input int hsw,
                                   input int hbp, input int va, input int vfp, input int vsw,
                                   input int vbp, input int k);
        obs_t e;
        int   ht, vt, p, h, v;
        ht    = ha + hfp + hsw + hbp;
        vt    = va + vfp + vsw + vbp;
        p     = (k / cdiv) % (ht * vt);
        h     = p % ht;
        v     = p / ht;
        e     = '0;
        e.stb = (k > 0) && (k % cdiv == 0);
        e.hs  = !((h >= ha + hfp) && (h < ha + hfp + hsw));
        e.vs  = !((v >= va + vfp) && (v < va + vfp + vsw));
        e.act = (h < ha) && (v < va);
        e.x   = e.act ? 10'(h) : 10'd0;
        e.y   = e.act ? 9'(v) : 9'd0;
        e.le  = e.stb && (h == 0);
        e.fe  = e.stb && (h == 0) && (v == va);
`ifdef VGA_TEST_PATTERN_EN
        e.pat = e.act ? 3'(h / 80) : 3'd0;
`endif
        return e;
    endfunction

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic cmp_cycle(input string nm, input int k, input obs_t got, input obs_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL cycle_%s k=%0d: got stb=%b hs=%b vs=%b act=%b x=%0d y=%0d le=%b fe=%b pat=%0d, expected stb=%b hs=%b vs=%b act=%b x=%0d y=%0d le=%b fe=%b pat=%0d",
                     nm, k, got.stb, got.hs, got.vs, got.act, got.x, got.y, got.le, got.fe, got.pat,
                     exp.stb, exp.hs, exp.vs, exp.act, exp.x, exp.y, exp.le, exp.fe, exp.pat);
        end
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_cycle("a", k_a, obs_a, model(2, 640, 16, 96, 48, 480, 10, 2, 33, k_a));
            cmp_cycle("b", k_b, obs_b, model(2, 16, 2, 4, 3, 8, 2, 2, 3, k_b));
            cmp_cycle("c", k_c, obs_c, model(1, 640, 16, 96, 48, 480, 10, 2, 33, k_c));
        end
    end

    // Reset value: at (0,0), visible, syncs idle, no strobes.
    obs_t rst_v;

    // Run statistics.
    int first_le_a = -1, le_cnt_a = 0, hs_fall_a = -1, hs_low_a = 0, act_a = 0;
    int first_fe_b = -1, fe_cnt_b = 0, vs_low_b = 0, last_px_b = 0, fe_no_le_b = 0;
    int stb_cnt_c = 0, first_le_c = -1, le_cnt_c = 0;
    int first_fe_b2 = -1, fe_cnt_b2 = 0, vs_low_b2 = 0;
    bit found;

    initial begin
        rst_v     = '0;
        rst_v.hs  = 1'b1;
        rst_v.vs  = 1'b1;
        rst_v.act = 1'b1;

        #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_vector_a", 32'(obs_a), 32'(rst_v));
        chk("reset_vector_c", 32'(obs_c), 32'(rst_v));

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            // Reset release details.
            if (k_a == 1) begin
                chk("a_k1_no_stb", int'(if_a.o_pix_stb), 0);
                chk("a_k1_x", int'(if_a.o_x), 0);
            end
            if (k_a == 2) begin
                chk("a_first_stb", int'(if_a.o_pix_stb), 1);
                chk("a_first_x", int'(if_a.o_x), 1);
                chk("a_first_y", int'(if_a.o_y), 0);
                chk("a_first_active", int'(if_a.o_active), 1);
                chk("a_first_hs", int'(if_a.o_hs), 1);
                chk("a_first_vs", int'(if_a.o_vs), 1);
            end
            if (k_c == 1) begin
                chk("c_first_stb", int'(if_c.o_pix_stb), 1);
                chk("c_first_x", int'(if_c.o_x), 1);
            end
`ifdef VGA_TEST_PATTERN_EN
            // Line v=1 of u_c starts at k=800; k=800+x shows column x.
            if (k_c == 800)  chk("pat_x0", int'(if_c.o_pattern), 0);
            if (k_c == 879)  chk("pat_x79", int'(if_c.o_pattern), 0);
            if (k_c == 880)  chk("pat_x80", int'(if_c.o_pattern), 1);
            if (k_c == 1439) chk("pat_x639", int'(if_c.o_pattern), 7);
            if (k_c == 1440) chk("pat_x640", int'(if_c.o_pattern), 0);
`endif
            // u_a: line-level timing, line v=1 spans k=1600..3199.
            if (if_a.o_line_end) begin
                le_cnt_a++;
                if (first_le_a < 0) first_le_a = k_a;
            end
            if (k_a >= 1600 && k_a < 3200) begin
                if (!if_a.o_hs) begin
                    hs_low_a++;
                    if (hs_fall_a < 0) hs_fall_a = k_a;
                end
                if (if_a.o_active) act_a++;
            end
            // u_b: frame-level timing, frame 1 spans k=750..1499.
            if (if_b.o_frame_end) begin
                fe_cnt_b++;
                if (first_fe_b < 0) first_fe_b = k_b;
                if (!if_b.o_line_end) fe_no_le_b++;
            end
            if (k_b >= 750 && k_b < 1500) begin
                if (!if_b.o_vs) vs_low_b++;
                if (if_b.o_active && if_b.o_x == 10'd15 && if_b.o_y == 9'd7) last_px_b++;
            end
            // u_c: strobe every clk.
            if (if_c.o_pix_stb) stb_cnt_c++;
            if (if_c.o_line_end) begin
                le_cnt_c++;
                if (first_le_c < 0) first_le_c = k_c;
            end
        end

        chk("a_first_line_end", first_le_a, 1600);
        chk("a_line_end_count", le_cnt_a, 3);
        chk("a_hs_fall_offset", hs_fall_a, 2912);
        chk("a_hs_low_clks", hs_low_a, 192);
        chk("a_active_clks", act_a, 1280);
        chk("b_first_frame_end", first_fe_b, 400);
        chk("b_frame_end_count", fe_cnt_b, 7);
        chk("b_frame_end_without_line_end", fe_no_le_b, 0);
        chk("b_vs_low_clks", vs_low_b, 100);
        chk("b_last_pixel_clks", last_px_b, 2);
        chk("c_stb_count", stb_cnt_c, 5000);
        chk("c_first_line_end", first_le_c, 800);
        chk("c_line_end_count", le_cnt_c, 6);

        // Mid-frame reset of u_b at (h=10, v=5): position 135, i.e. k%750 == 270.
        found = 1'b0;
        for (int c = 0; c < 800 && !found; c++) begin
            @(negedge clk);
            if (k_b % 750 == 270) found = 1'b1;
        end
        chk("b_midframe_reached", int'(found), 1);
        chk("b_midframe_x_before", int'(if_b.o_x), 10);
        #2 rst_b = 1'b0;
        #1;
        chk("b_async_reset_vector", 32'(obs_b), 32'(rst_v));
        @(negedge clk);
        rst_b = 1'b1;

        for (int c = 0; c < 1600; c++) begin
            @(negedge clk);
            if (if_b.o_frame_end) begin
                fe_cnt_b2++;
                if (first_fe_b2 < 0) first_fe_b2 = k_b;
            end
            if (k_b >= 750 && k_b < 1500 && !if_b.o_vs) vs_low_b2++;
        end
        chk("b_restart_first_frame_end", first_fe_b2, 400);
        chk("b_restart_frame_end_count", fe_cnt_b2, 2);
        chk("b_restart_vs_low_clks", vs_low_b2, 100);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
